// File: rtl/alu_pkg.sv
// ALU opcode set, request bundle and arbiter sizing limit shared by the ALU, its arbiter and clients.
// Pure type/constant package: no logic, no latency, no flow control.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } Op;

    localparam int ALU_ARB_MAX_N = 4;

    typedef struct packed {
        Op          op;
        logic [7:0] a;
        logic [7:0] b;
    } AluReq;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU: zero latency, no flow control (result is valid whenever inputs are).
// Shift amounts use all 8 bits of b, so shifts by 8 or more flush to zero / sign fill.
module Alu
    import alu_pkg::*;
(
    input  Op          op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] x
);

    always_comb begin
        x = '0;
        case (op)
            OP_ADD:  x = a + b;
            OP_SUB:  x = a - b;
            OP_AND:  x = a & b;
            OP_OR:   x = a | b;
            OP_XOR:  x = a ^ b;
            OP_SLL:  x = a << b;
            OP_SRL:  x = a >> b;
            OP_SRA:  x = $signed(a) >>> b;
            OP_SLT:  x = {7'd0, $signed(a) < $signed(b)};
            OP_SLTU: x = {7'd0, a < b};
            default: x = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among N requesters; result registered 1 cycle after accept, tagged with winner id.
// A stalled result (rsp_valid && !rsp_ready) blocks all grants; ALU_ARB_STATS_EN adds per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 2,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  Op               req_op [N],
    input  logic [7:0]      req_a  [N],
    input  logic [7:0]      req_b  [N],
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_x,
    output logic [ID_W-1:0] rsp_id
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic            stats_clr,
    output logic [15:0]     grant_count [N]
`endif
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_x_q, rsp_x_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] prio_q, prio_d;

    logic            can_issue;
    logic            win_vld;
    logic [ID_W-1:0] win_idx;
    logic            accept;
    AluReq           alu_in;
    logic [7:0]      alu_x;

    assign can_issue = !rsp_valid_q || rsp_ready;
    assign accept    = win_vld && can_issue && !rst;

    // First valid requester found scanning upward from prio, wrapping at N.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!win_vld && req_valid[j] && (((int'(prio_q) + off) % N) == j)) begin
                    win_vld = 1'b1;
                    win_idx = ID_W'(j);
                end
            end
        end
    end

    // Idle cycles park the ALU on requester 0; its result is simply not captured.
    always_comb begin
        req_ready = '0;
        alu_in.op = req_op[0];
        alu_in.a  = req_a[0];
        alu_in.b  = req_b[0];
        for (int j = 0; j < N; j++) begin
            if (accept && (win_idx == ID_W'(j))) begin
                req_ready[j] = 1'b1;
                alu_in.op    = req_op[j];
                alu_in.a     = req_a[j];
                alu_in.b     = req_b[j];
            end
        end
    end

    Alu u_alu (
        .op (alu_in.op),
        .a  (alu_in.a),
        .b  (alu_in.b),
        .x  (alu_x)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_x_d     = rsp_x_q;
        rsp_id_d    = rsp_id_q;
        prio_d      = prio_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_x_d     = alu_x;
            rsp_id_d    = win_idx;
            prio_d      = (win_idx == ID_W'(N - 1)) ? '0 : win_idx + ID_W'(1);
        end else if (rsp_ready && rsp_valid_q) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_x_q     <= '0;
            rsp_id_q    <= '0;
            prio_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_x_q     <= rsp_x_d;
            rsp_id_q    <= rsp_id_d;
            prio_q      <= prio_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gcnt_q [N];
    logic [15:0] gcnt_d [N];

    // Clear beats a coincident accept; counters stick at all-ones.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            gcnt_d[j] = gcnt_q[j];
            if (stats_clr) begin
                gcnt_d[j] = '0;
            end else if (req_ready[j] && (gcnt_q[j] != 16'hFFFF)) begin
                gcnt_d[j] = gcnt_q[j] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (rst) begin
                gcnt_q[j] <= '0;
            end else begin
                gcnt_q[j] <= gcnt_d[j];
            end
        end
    end

    assign grant_count = gcnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic against a behavioural model.
// With ALU_ARB_STATS_EN the DUT is built with four requesters and the grant counters are checked too.
module tb_alu_arbiter;
    import alu_pkg::*;

`ifdef ALU_ARB_STATS_EN
    localparam int NREQ = 4;
`else
    localparam int NREQ = 2;
`endif
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    Op               req_op [NREQ];
    logic [7:0]      req_a  [NREQ];
    logic [7:0]      req_b  [NREQ];
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_x;
    logic [IDW-1:0]  rsp_id;
`ifdef ALU_ARB_STATS_EN
    logic            stats_clr;
    logic [15:0]     grant_count [NREQ];
    int              m_gcnt [NREQ];
`endif

    typedef struct {
        logic [7:0] x;
        int         id;
    } exp_t;

    exp_t            sb_q [$];
    AluReq           pend [NREQ];
    logic [NREQ-1:0] pend_vld;
    int              m_prio;
    bit              m_rsp_vld;
    bit              m_acc;
    int              m_win;
    int              n_checks = 0;
    int              n_fail   = 0;

    alu_arbiter #(.N(NREQ), .ID_W(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_x      (rsp_x),
        .rsp_id     (rsp_id)
`ifdef ALU_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic.
    function automatic logic [7:0] ref_alu(input AluReq r);
        int a, b, sa, sb, v;
        a  = int'(r.a);
        b  = int'(r.b);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (r.op)
            OP_ADD:  v = a + b;
            OP_SUB:  v = a - b;
            OP_AND:  v = a & b;
            OP_OR:   v = a | b;
            OP_XOR:  v = a ^ b;
            OP_SLL:  v = (b >= 8) ? 0 : a * (2 ** b);
            OP_SRL:  v = (b >= 8) ? 0 : a / (2 ** b);
            OP_SRA:  v = (b >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
            OP_SLT:  v = (sa < sb) ? 1 : 0;
            OP_SLTU: v = (a < b) ? 1 : 0;
            default: v = 0;
        endcase
        return v[7:0];
    endfunction

    task automatic set_req(input int i, input Op op, input logic [7:0] a, input logic [7:0] b);
        pend[i].op  = op;
        pend[i].a   = a;
        pend[i].b   = b;
        pend_vld[i] = 1'b1;
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend_vld[i];
            req_op[i]    = pend[i].op;
            req_a[i]     = pend[i].a;
            req_b[i]     = pend[i].b;
        end
    endtask

    // One clock: drive, check grant at negedge, advance model at posedge.
    task automatic step();
        int exp_rdy;
        apply();
        @(negedge clk);
        m_acc = 1'b0;
        m_win = 0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_prio + k) % NREQ;
                if (!m_acc && pend_vld[i]) begin
                    m_acc = 1'b1;
                    m_win = i;
                end
            end
            if (m_rsp_vld && !rsp_ready) m_acc = 1'b0;
            chk("rsp_valid", int'(rsp_valid), int'(m_rsp_vld));
`ifdef ALU_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) chk("grant_count", int'(grant_count[i]), m_gcnt[i]);
`endif
        end
        exp_rdy = m_acc ? (1 << m_win) : 0;
        chk("req_ready", int'(req_ready), exp_rdy);
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
            m_prio    = 0;
            m_rsp_vld = 1'b0;
`ifdef ALU_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
`endif
        end else begin
`ifdef ALU_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) begin
                if (stats_clr) m_gcnt[i] = 0;
                else if (m_acc && m_win == i && m_gcnt[i] < 65535) m_gcnt[i]++;
            end
`endif
            if (m_acc) begin
                sb_q.push_back('{ref_alu(pend[m_win]), m_win});
                m_rsp_vld      = 1'b1;
                m_prio         = (m_win + 1) % NREQ;
                pend_vld[m_win] = 1'b0;
            end else if (rsp_ready && m_rsp_vld) begin
                m_rsp_vld = 1'b0;
            end
        end
        #1;
    endtask

    // Monitor: any presented result must match the oldest expected one; pop when consumed.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_x", int'(rsp_x), int'(sb_q[0].x));
                chk("rsp_id", int'(rsp_id), sb_q[0].id);
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        pend_vld  = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = '0;
        rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_valid", int'(rsp_valid), 0);
        chk("reset_x", int'(rsp_x), 0);
        chk("reset_id", int'(rsp_id), 0);

        // Single requester SUB wraps to 0xFE.
        rsp_ready = 1'b1;
        set_req(1, OP_SUB, 8'h05, 8'h07);
        step();
        chk("sub_valid", int'(rsp_valid), 1);
        chk("sub_x", int'(rsp_x), 8'hFE);
        chk("sub_id", int'(rsp_id), 1);
        step();
        chk("sub_drop", int'(rsp_valid), 0);

        // Contention alternates between the two requesters.
        for (int k = 0; k < 6; k++) begin
            set_req(0, OP_ADD, 8'd3, 8'd4);
            set_req(1, OP_SLT, 8'h80, 8'h01);
            step();
            chk("cont_id", int'(rsp_id), k % 2);
            chk("cont_x", int'(rsp_x), (k % 2) ? 1 : 7);
        end
        pend_vld = '0;
        step();

        // Backpressure: stalled output blocks grants and holds its value.
        set_req(0, OP_ADD, 8'd10, 8'd20);
        step();
        chk("bp_first_x", int'(rsp_x), 30);
        rsp_ready = 1'b0;
        set_req(0, OP_XOR, 8'hF0, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_x", int'(rsp_x), 30);
            chk("bp_hold_valid", int'(rsp_valid), 1);
            chk("bp_rdy", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_next_x", int'(rsp_x), 8'hCC);
        chk("bp_next_id", int'(rsp_id), 0);
        chk("bp_next_valid", int'(rsp_valid), 1);

        // All ten opcodes, then the shift / compare corner cases.
        for (int o = 0; o < 10; o++) begin
            set_req(o % NREQ, Op'(o), 8'($urandom), 8'($urandom_range(0, 12)));
            step();
        end
        set_req(0, OP_SRA, 8'h90, 8'd2);
        step();
        chk("sra", int'(rsp_x), 8'hE4);
        set_req(1, OP_SRL, 8'h90, 8'd2);
        step();
        chk("srl", int'(rsp_x), 8'h24);
        set_req(0, OP_SLL, 8'h01, 8'd9);
        step();
        chk("sll9", int'(rsp_x), 8'h00);
        set_req(1, OP_SLTU, 8'h80, 8'h01);
        step();
        chk("sltu", int'(rsp_x), 0);
        step();

        // Reset in the middle of a stall.
        rsp_ready = 1'b0;
        set_req(0, OP_OR, 8'h0F, 8'h30);
        step();
        set_req(0, OP_ADD, 8'd1, 8'd1);
        set_req(1, OP_AND, 8'hFF, 8'h0F);
        step();
        step();
        chk("stall_x", int'(rsp_x), 8'h3F);
        rst = 1'b1;
        step();
        chk("rst_rdy", int'(req_ready), 0);
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_x", int'(rsp_x), 0);
        chk("rst_id", int'(rsp_id), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("rst_prio_id", int'(rsp_id), 0);
        chk("rst_prio_x", int'(rsp_x), 2);
        pend_vld = '0;
        step();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_vld[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, Op'($urandom_range(0, 9)), 8'($urandom), 8'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef ALU_ARB_STATS_EN
        // Grant counters: ten round-robin grants, then clear racing an accept.
        pend_vld = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 8'(i), 8'd1);
            step();
        end
        chk("gcnt0", int'(grant_count[0]), 3);
        chk("gcnt1", int'(grant_count[1]), 3);
        chk("gcnt2", int'(grant_count[2]), 2);
        chk("gcnt3", int'(grant_count[3]), 2);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) chk("gcnt_clr", int'(grant_count[i]), 0);
`endif

        pend_vld  = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `Alu` instance between `N` requesters. Each requester presents an operation with a valid/ready handshake. A round-robin arbiter grants one request per cycle. The block captures the ALU result in a single-entry output register, tagged with the winner's index. It sits between the issuing agents and the ALU, and is the only driver of the ALU inputs.

## Interface
- `N`, default 2: number of requesters; legal values 2..4.
- `ID_W`, default 2: width of the requester index; must satisfy 2^ID_W ≥ N.
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `req_valid`  in  [N]  requester i holds an operation.
- `req_ready`  out  [N]  requester i's operation is accepted this cycle.
- `req_op`  in  [N] x `alu_pkg::Op`  operation code per requester.
- `req_a`, `req_b`  in  [N] x 8  operands per requester.
- `rsp_valid`  out  1  output register holds a result.
- `rsp_ready`  in  1  consumer takes the result this cycle.
- `rsp_x`  out  8  ALU result.
- `rsp_id`  out  ID_W  index of the requester that issued the result.

## Operation
- Registers:
  - output register: `rsp_valid`, `rsp_x`, `rsp_id`.
  - round-robin pointer `prio` (ID_W bits): index of the highest-priority requester.
- `can_issue = !rsp_valid || rsp_ready`.
- Grant selection:
  - Scan from `prio` upward modulo N; the first i with `req_valid[i]=1` wins.
  - At most one `req_ready` bit is high per cycle.
  - `req_ready[i]` is high only for the winner, and only when `can_issue` is high.
  - `req_ready` is combinational from `req_valid`, `prio` and `can_issue`. It never depends on `rsp_x`.
- On accept (winner i, `can_issue`):
  - The winner's op and operands drive the ALU.
  - Next edge: `rsp_x` ← ALU result, `rsp_id` ← i, `rsp_valid` ← 1, `prio` ← (i+1) mod N.
- No accept and `rsp_ready && rsp_valid`: `rsp_valid` ← 0.
- Idle cycles: ALU inputs are driven from requester 0 (don't-care value). `prio` holds.
- Simultaneous drain and accept: the new result replaces the drained one in the same edge. There is no bubble.
- Output stall (`rsp_valid && !rsp_ready`):
  - `rsp_x` and `rsp_id` are held stable.
  - All `req_ready` bits are 0.
  - `prio` holds.
- Requesters must hold valid, op and operands stable until accepted.
- Result values follow the ALU:
  - 8-bit wrap on ADD and SUB.
  - SLT and SLTU yield 0 or 1, zero-extended.
  - Shifts use the full 8-bit `b`.
- Reset (any cycle, including mid-stall):
  - `rsp_valid`=0, `rsp_x`=0, `rsp_id`=0, `prio`=0.
  - Any pending output result is discarded.
  - `req_ready` is 0 for the reset cycle.

## Timing
- Request-to-response latency: 1 cycle; accept at edge k gives `rsp_valid` after edge k.
- Throughput: 1 operation per cycle while `rsp_ready` stays high.
- Fairness: with all N requesters continuously valid and no stall, each is granted exactly once in every N consecutive grants.
- The ALU is purely combinational between the operand mux and the output register. There is no internal pipeline.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Adds output `grant_count`, [N] x 16: per-requester accepted-operation counters.
  - Counters increment on each accept of requester i and saturate at 16'hFFFF.
  - Reset to 0 by `rst`.
  - Input `stats_clr` (1 bit, synchronous) zeroes all counters. If clear and accept coincide, clear wins.
- `ALU_ARB_STATS_EN` undefined: the port, input and counters do not exist. All other behaviour is identical.

## Structure
- `alu_pkg` holds the existing `Op` enum.
- Add to `alu_pkg`:
  - `localparam int ALU_ARB_MAX_N = 4`.
  - packed struct `AluReq` {`Op` op; `logic [7:0] a`; `logic [7:0] b`}, which the bench also uses.
- One sub-module: the existing `Alu`, instantiated once. The arbiter logic and the output register stay in `alu_arbiter`.

## Test plan
- Reset mid-stall: fill the output, hold `rsp_ready`=0, assert `rst` → next cycle `rsp_valid`=0, `rsp_x`=0, `rsp_id`=0, `prio`=0, `req_ready`=0 during reset.
- Single requester, N=2: req1 SUB a=8'h05 b=8'h07, `rsp_ready`=1 → one cycle later `rsp_x`=8'hFE, `rsp_id`=1, then `rsp_valid` drops.
- Contention: both valid every cycle, req0 ADD 3+4, req1 SLT 8'h80 vs 8'h01, `rsp_ready`=1 → results alternate 7 (id 0), 1 (id 1), 7, 1… starting with id 0.
- Backpressure: result pending, `rsp_ready`=0 for 3 cycles with req0 valid → `req_ready`=0 and `rsp_x` stable for all 3 cycles. When `rsp_ready` rises, req0 is accepted that cycle and its result follows on the next edge with no bubble.
- Shift and op coverage, all ten ops: SRA 8'h90 by 2 → 8'hE4; SRL 8'h90 by 2 → 8'h24; SLL 8'h01 by 9 → 8'h00; SLTU 8'h80 vs 8'h01 → 0.
- With `ALU_ARB_STATS_EN`, N=4: 10 grants round-robin with all valid → `grant_count` = {3,3,2,2} for ids 0..3. Then `stats_clr` coincident with an accept → all counters 0.
